skolem_check_bvugt_bvmul: RTL and testbench

- Checker that consumes a candidate Skolem witness x for the invertibility problem bvugt(bvmul(x,s),t) over W-bit words, i.e. the goal is (x*s mod 2^W) >u t.
- It sits downstream of the Skolem-function generators and uses one serial shift-add multiplier.
- It first checks the candidate x. If x fails, it searches y=0..2^W-1 for any valid witness. The verdict is one of PASS, WRONG (a witness exists but x is not one) or VACUOUS (no witness exists).
- Pass and fail counts are accumulated for regression sign-off.

---
 rtl/skolem_check_bvugt_bvmul.sv | 166 ++++++++++++++++
 tb/tb_skolem_check_bvugt_bvmul.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/skolem_check_bvugt_bvmul.sv
// Checks a candidate Skolem witness x for (x*s mod 2^W) >u t with one serial shift-add
// multiplier. If x fails, it scans y = 0..2^W-1 for any witness. Verdict: PASS, WRONG or VACUOUS.
module skolem_check_bvugt_bvmul #(
  parameter int W  = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  s,
  input  logic [W-1:0]  t,
  input  logic [W-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    verdict,
  output logic [W-1:0]  product,
  output logic [W-1:0]  witness,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic [1:0]    dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE. out_valid is high only in DONE, and results are held until out_ready.
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [1:0] V_PASS = 2'b00;
  localparam logic [1:0] V_WRONG = 2'b01;
  localparam logic [1:0] V_VAC = 2'b10;
  localparam logic [W:0] Y_LAST = {1'b0, {W{1'b1}}};
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, EVAL_X, SEARCH, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  s_q, s_d, t_q, t_d, x_q, x_d, acc_q, acc_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [W:0]    y_q, y_d;
  logic [1:0]    verdict_q, verdict_d;
  logic [W-1:0]  product_q, product_d, witness_q, witness_d;
  logic [CW-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;

  logic [W-1:0]  y_lo, addend, acc_sum;
  logic          mult_bit, hit, last_bit;

  // EVAL_X and SEARCH share one datapath. The only difference is which word supplies the multiplier bits.
  always_comb begin
    y_lo     = y_q[W-1:0];
    mult_bit = (state_q == EVAL_X) ? x_q[bit_q] : y_lo[bit_q];
    addend   = mult_bit ? (s_q << bit_q) : '0;
    acc_sum  = acc_q + addend;
    hit      = acc_sum > t_q;
    last_bit = bit_q == BIT_LAST;
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    t_d        = t_q;
    x_d        = x_q;
    acc_d      = acc_q;
    bit_d      = bit_q;
    y_d        = y_q;
    verdict_d  = verdict_q;
    product_d  = product_q;
    witness_d  = witness_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = s;
          t_d     = t;
          x_d     = x;
          acc_d   = '0;
          bit_d   = '0;
          y_d     = '0;
          state_d = EVAL_X;
        end
      end
      EVAL_X: begin
        acc_d = acc_sum;
        bit_d = bit_q + BW'(1);
        if (last_bit) begin
          product_d = acc_sum;
          acc_d     = '0;
          bit_d     = '0;
          if (hit) begin
            verdict_d = V_PASS;
            witness_d = x_q;
            state_d   = DONE;
          end else begin
            y_d     = '0;
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        acc_d = acc_sum;
        bit_d = bit_q + BW'(1);
        if (last_bit) begin
          acc_d = '0;
          bit_d = '0;
          if (hit) begin
            verdict_d = V_WRONG;
            witness_d = y_lo;
            state_d   = DONE;
          end else if (y_q == Y_LAST) begin
            verdict_d = V_VAC;
            witness_d = '0;
            state_d   = DONE;
          end else begin
            y_d = y_q + (W+1)'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (verdict_q == V_PASS && pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CW'(1);
          if (verdict_q == V_WRONG && fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s_q        <= '0;
      t_q        <= '0;
      x_q        <= '0;
      acc_q      <= '0;
      bit_q      <= '0;
      y_q        <= '0;
      verdict_q  <= '0;
      product_q  <= '0;
      witness_q  <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      t_q        <= t_d;
      x_q        <= x_d;
      acc_q      <= acc_d;
      bit_q      <= bit_d;
      y_q        <= y_d;
      verdict_q  <= verdict_d;
      product_q  <= product_d;
      witness_q  <= witness_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign verdict   = verdict_q;
  assign product   = product_q;
  assign witness   = witness_q;
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_skolem_check_bvugt_bvmul.sv
// Bench for skolem_check_bvugt_bvmul. It runs directed and random jobs and compares each result
// against an arithmetic reference model, using an expected queue.
module tb_skolem_check_bvugt_bvmul;
  localparam int W  = 4;
  localparam int CW = 16;

  logic          clk, rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  s, t, x, product, witness;
  logic [1:0]    verdict, dbg_state;
  logic [CW-1:0] pass_cnt, fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pass = 0;
  int exp_fail = 0;
  logic [2+2*W+7:0] exp_q[$];

  skolem_check_bvugt_bvmul #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .t(t), .x(x), .out_valid(out_valid), .out_ready(out_ready),
    .verdict(verdict), .product(product), .witness(witness),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: scan candidates in order using plain modular arithmetic.
  // Expected entry layout: {latency[7:0], verdict[1:0], product, witness}
  function automatic logic [2+2*W+7:0] model(input int ms, input int mt, input int mx);
    int  mod = 1 << W;
    int  prod = (ms * mx) % mod;
    int  lat;
    if (prod > mt) return {8'(W + 1), 2'b00, W'(prod), W'(mx)};
    for (int y = 0; y < mod; y++) begin
      if (((ms * y) % mod) > mt) begin
        lat = W + 1 + (y + 1) * W;
        return {8'(lat), 2'b01, W'(prod), W'(y)};
      end
    end
    lat = W + 1 + mod * W;
    return {8'(lat), 2'b10, W'(prod), W'(0)};
  endfunction

  // driver: one complete job, with `hold` cycles of backpressure once the verdict appears
  task automatic do_job(input logic [W-1:0] js, input logic [W-1:0] jt, input logic [W-1:0] jx,
                        input int hold);
    int cyc;
    int waitc;
    logic [2+2*W+7:0] e;
    logic [1:0]   h_v;
    logic [W-1:0] h_p, h_w, neg_or;
    exp_q.push_back(model(int'(js), int'(jt), int'(jx)));
    waitc = 0;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check("idle_ready", in_ready, 1);
    s = js; t = jt; x = jx; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("in_ready_drop", in_ready, 0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 200);
    e = exp_q.pop_front();
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", cyc, int'(e[2+2*W+7 -: 8]));
    check("verdict", verdict, e[2*W+1 -: 2]);
    check("product", product, e[2*W-1 -: W]);
    check("witness", witness, e[W-1:0]);
    neg_or = (-js) | js;
    check("vacuous_inv", verdict == 2'b10, !(jt < neg_or));
    h_v = verdict; h_p = product; h_w = witness;
    for (int h = 0; h < hold; h++) begin
      s = W'($urandom_range(0, 15)); t = W'($urandom_range(0, 15));
      x = W'($urandom_range(0, 15)); in_valid = 1'b1;
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_ready", in_ready, 0);
      check("bp_stable", {verdict, product, witness}, {h_v, h_p, h_w});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    if (h_v == 2'b00 && exp_pass < (1 << CW) - 1) exp_pass++;
    if (h_v == 2'b01 && exp_fail < (1 << CW) - 1) exp_fail++;
    check("post_ready", in_ready, 1);
    check("post_valid", out_valid, 0);
    check("pass_cnt", pass_cnt, exp_pass);
    check("fail_cnt", fail_cnt, exp_fail);
  endtask

  task automatic reset_mid_job();
    int cyc;
    s = 3; t = 5; x = 1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_reset_busy", out_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    exp_pass = 0;
    exp_fail = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {verdict, product, witness}, 0);
    check("rst_counters", {pass_cnt, fail_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_verdict", out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s = '0; t = '0; x = '0;
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", {verdict, product, witness}, 0);
    check("reset_counters", {pass_cnt, fail_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_job(4'd3, 4'd5, 4'd2, 0);
    do_job(4'd3, 4'd5, 4'd1, 0);
    do_job(4'd4, 4'd12, 4'd3, 0);
    do_job(4'd0, 4'd0, 4'd7, 0);
    do_job(4'd15, 4'd0, 4'd15, 0);
    do_job(4'd3, 4'd5, 4'd2, 10);
    do_job(4'd1, 4'd15, 4'd9, 2);
    reset_mid_job();
    do_job(4'd3, 4'd5, 4'd1, 0);
    for (int i = 0; i < 30; i++)
      do_job(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
